// File: rtl/clk_ce_reset_seq_if.sv
// Lock input and sequenced clock-enable/reset outputs of clk_ce_reset_seq.
// The increment write port exists only when CLKCESEQ_RUNTIME_INC_EN is defined.
interface clk_ce_reset_seq_if #(
  parameter int NCH   = 3,
  parameter int ACC_W = 24
);
  logic             locked_i;
  logic [NCH-1:0]   ce_o;
  logic [NCH-1:0]   rst_n_o;
  logic             ready_o;
  logic             lock_lost_o;
`ifdef CLKCESEQ_RUNTIME_INC_EN
  logic             wr_i;
  logic [1:0]       wr_ch_i;
  logic [ACC_W-1:0] wr_inc_i;

  modport slave  (input  locked_i, wr_i, wr_ch_i, wr_inc_i,
                  output ce_o, rst_n_o, ready_o, lock_lost_o);
  modport master (output locked_i, wr_i, wr_ch_i, wr_inc_i,
                  input  ce_o, rst_n_o, ready_o, lock_lost_o);
`else
  modport slave  (input  locked_i,
                  output ce_o, rst_n_o, ready_o, lock_lost_o);
  modport master (output locked_i,
                  input  ce_o, rst_n_o, ready_o, lock_lost_o);
`endif
endinterface

// File: rtl/clk_ce_reset_seq.sv
// PLL lock filter, ordered per-channel reset release and phase-accumulator clock enables.
// Defining CLKCESEQ_RUNTIME_INC_EN adds writable per-channel increment registers.
module clk_ce_reset_seq #(
  parameter int              NCH       = 3,
  parameter int              ACC_W     = 24,
  parameter longint unsigned CLK_HZ    = 64'd50000000,
  parameter longint unsigned OUT0_HZ   = 64'd5000000,
  parameter longint unsigned OUT1_HZ   = 64'd1000000,
  parameter longint unsigned OUT2_HZ   = 64'd3000000,
  parameter longint unsigned OUT3_HZ   = 64'd25000000,
  parameter int              LOCK_FILT = 16,
  parameter int              RST_GAP   = 4
) (
  input logic               clki,
  input logic               resetn,
  clk_ce_reset_seq_if.slave bus
);

  // state     | meaning
  // WAIT_LOCK | everything held in reset, waiting for synchronised lock
  // STABLE    | counting LOCK_FILT consecutive lock cycles
  // RELEASE   | releasing channel resets one by one, RST_GAP apart
  // RUN       | all channels released, ready_o high
  typedef enum logic [1:0] {WAIT_LOCK, STABLE, RELEASE, RUN} state_t;

  localparam int CNT_MAX = (LOCK_FILT > RST_GAP) ? LOCK_FILT : RST_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] FILT_LOAD = CNT_W'(LOCK_FILT - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(RST_GAP - 1);

  function automatic longint unsigned out_hz(input int n);
    case (n)
      0:       return OUT0_HZ;
      1:       return OUT1_HZ;
      2:       return OUT2_HZ;
      default: return OUT3_HZ;
    endcase
  endfunction

  // round(out * 2^ACC_W / clk), clamped so a near-clk rate cannot wrap to zero
  function automatic longint unsigned inc_calc(input int n);
    longint unsigned r;
    r = ((out_hz(n) << (ACC_W + 1)) + CLK_HZ) / (CLK_HZ << 1);
    if (r > ((64'd1 << ACC_W) - 64'd1)) r = (64'd1 << ACC_W) - 64'd1;
    return r;
  endfunction

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       idx, idx_d;
  logic [NCH-1:0]   rst_q, rst_d;
  logic             ready_q, ready_d, lost_q, lost_d;
  logic             lock_meta, lock_s;
  logic [NCH-1:0]   ce_v;

  always_ff @(posedge clki or negedge resetn) begin
    if (!resetn) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= bus.locked_i;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge clki or negedge resetn) begin
    if (!resetn) begin
      state   <= WAIT_LOCK;
      cnt     <= '0;
      idx     <= '0;
      rst_q   <= '0;
      ready_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      idx     <= idx_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      lost_q  <= lost_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    case (state)
      WAIT_LOCK: begin
        idx_d = '0;
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = FILT_LOAD;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt == '0) begin
          state_d = (NCH == 1) ? RUN : RELEASE;
          cnt_d   = GAP_LOAD;
          idx_d   = '0;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          idx_d   = '0;
        end else if (cnt == '0) begin
          idx_d = idx + 2'd1;
          cnt_d = GAP_LOAD;
          if (int'(idx) + 1 >= NCH - 1) state_d = RUN;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          idx_d   = '0;
        end
      end
    endcase
  end

  // Outputs are registered from the next state so resets stay glitch-free
  always_comb begin
    lost_d  = ((state == RELEASE) || (state == RUN)) && !lock_s;
    ready_d = (state_d == RUN);
    rst_d   = '0;
    for (int i = 0; i < NCH; i++)
      rst_d[i] = (state_d == RUN) || ((state_d == RELEASE) && (int'(idx_d) >= i));
  end

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    if (out_hz(n) >= CLK_HZ) begin : g_byp
      logic ce_q;
      always_ff @(posedge clki or negedge resetn) begin
        if (!resetn) ce_q <= 1'b0;
        else         ce_q <= rst_d[n];
      end
      assign ce_v[n] = ce_q;
    end else begin : g_acc
      localparam logic [ACC_W-1:0] INC = ACC_W'(inc_calc(n));
      logic [ACC_W-1:0] acc, inc;
      logic [ACC_W:0]   sum;
      logic             ce_q, wr_hit;
`ifdef CLKCESEQ_RUNTIME_INC_EN
      assign wr_hit = bus.wr_i && (bus.wr_ch_i == 2'(n));
      always_ff @(posedge clki or negedge resetn) begin
        if (!resetn)     inc <= INC;
        else if (wr_hit) inc <= bus.wr_inc_i;
      end
`else
      assign wr_hit = 1'b0;
      assign inc    = INC;
`endif
      assign sum = {1'b0, acc} + {1'b0, inc};
      // Accumulate only once the channel has been out of reset for a full cycle
      always_ff @(posedge clki or negedge resetn) begin
        if (!resetn) begin
          acc  <= '0;
          ce_q <= 1'b0;
        end else if (wr_hit || !(rst_q[n] && rst_d[n])) begin
          acc  <= '0;
          ce_q <= 1'b0;
        end else begin
          acc  <= sum[ACC_W-1:0];
          ce_q <= sum[ACC_W];
        end
      end
      assign ce_v[n] = ce_q;
    end
  end

  assign bus.ce_o        = ce_v;
  assign bus.rst_n_o     = rst_q;
  assign bus.ready_o     = ready_q;
  assign bus.lock_lost_o = lost_q;

endmodule

// File: doc/clk_ce_reset_seq.md
Name: clk_ce_reset_seq

Overview:
- Parametrised successor to the fixed-ratio PLL clock wrapper.
- Runs on one fast PLL output and generates up to 4 fractional-rate clock-enable strobes (phase accumulators), e.g. a 5 MHz CPU enable from a 50 MHz clock, instead of extra PLL outputs.
- Also synchronises and filters the PLL lock, and releases per-channel resets in a fixed order.
- Sits directly after the PLL wrapper; feeds CPU, video and peripheral domains.

Parameters:
- NCH, 3, number of channels, 1..4
- ACC_W, 24, accumulator width in bits
- CLK_HZ, 50000000, frequency of clki
- OUT0_HZ, 5000000, channel 0 enable rate
- OUT1_HZ, 1000000, channel 1 enable rate
- OUT2_HZ, 3000000, channel 2 enable rate
- OUT3_HZ, 25000000, channel 3 enable rate
- LOCK_FILT, 16, consecutive synchronised-lock cycles required before release (>=1)
- RST_GAP, 4, cycles between successive channel reset releases (>=1)

Ports:
- clki  in  1  system clock (fast PLL output)
- resetn  in  1  asynchronous active-low reset
- locked_i  in  1  PLL lock, asynchronous to clki
- ce_o  out  NCH  per-channel one-cycle clock-enable strobes
- rst_n_o  out  NCH  per-channel active-low resets, synchronous deassert
- ready_o  out  1  all channels released and running
- lock_lost_o  out  1  one-cycle pulse on lock loss after release began

Behaviour:
- **Reset.** resetn low asynchronously forces:
  - ce_o=0, rst_n_o=0, ready_o=0, lock_lost_o=0
  - accumulators=0, state=WAIT_LOCK, 2-flop lock synchroniser=0
- **Lock synchroniser.** locked_i passes through 2 flops; the output is lock_s.
- **Per-channel increment.** INCn = round(OUTn_HZ * 2^ACC_W / CLK_HZ), computed at elaboration.
  - If OUTn_HZ >= CLK_HZ, the channel is in bypass: ce_o[n]=1 every cycle while rst_n_o[n]=1.
- **FSM:**
  - WAIT_LOCK: if lock_s=1, go to STABLE with cnt=0.
  - STABLE:
    - lock_s=0: go to WAIT_LOCK.
    - cnt==LOCK_FILT-1: go to RELEASE with cnt=0.
    - otherwise: cnt++.
  - RELEASE:
    - rst_n_o[0] rises on entry.
    - rst_n_o[i] rises i*RST_GAP cycles after entry.
    - In the cycle rst_n_o[NCH-1] rises, the state becomes RUN and ready_o rises together with it.
  - RUN: steady state.
  - In RELEASE or RUN, lock_s=0 causes, on the next edge:
    - state=WAIT_LOCK
    - all rst_n_o=0, ce_o=0, ready_o=0, accumulators cleared
    - lock_lost_o=1 for exactly one cycle
  - A lock drop in STABLE does not pulse lock_lost_o.
- **Latency.** rst_n_o[0] rises LOCK_FILT+3 clki edges after locked_i rises synchronously to clki and stays high.
- **Accumulator (channel n):**
  - Held at 0 with ce_o[n]=0 while rst_n_o[n]=0.
  - Once released, each cycle: {carry, acc} = acc + INCn, with acc kept mod 2^ACC_W.
  - ce_o[n] is the registered carry, so the first strobe can appear no earlier than 2 cycles after release.
  - INCn=0 gives ce_o[n] permanently 0.
- **Rate.** Average strobe rate is exact to INCn quantisation; spacing between strobes alternates between floor and ceil of 2^ACC_W/INCn.
- **Unused channels.** Channels >= NCH are not instantiated.

Optional Feature:
- Macro: CLKCESEQ_RUNTIME_INC_EN.
- **Defined.** Adds these ports:
  - wr_i  in  1
  - wr_ch_i  in  2
  - wr_inc_i  in  ACC_W
- Each channel has an increment register, reset by resetn to INCn.
- When wr_i=1 at an edge:
  - Channel wr_ch_i's register is loaded and its accumulator is cleared.
  - The new rate applies from the next cycle.
  - Writes with wr_ch_i >= NCH are ignored.
- Written values survive lock loss.
- A written value never enters bypass; bypass is determined only by parameters.
- **Undefined.** Increments are constants; the extra ports are absent.

Test Plan:
- Defaults; release resetn; assert locked_i synchronously.
  - rst_n_o[0] rises at edge 19.
  - rst_n_o[1] rises at edge 23.
  - rst_n_o[2] rises at edge 27, together with ready_o.
- Defaults after ready_o; count ce_o[0] over 10000 cycles -> exactly 1000 pulses, each spacing 10 cycles.
  - ce_o[1]: 200 pulses.
  - ce_o[2]: 600 pulses, spacings of 16 or 17.
- Pulse locked_i low for 1 cycle at edge 10 of STABLE.
  - Filter restarts; no lock_lost_o pulse.
  - Release is delayed accordingly.
- Drop locked_i during RUN.
  - lock_lost_o is high for 1 cycle.
  - All rst_n_o, ce_o and ready_o are 0 by the edge after lock_s falls.
  - Relock repeats the full release sequence.
- NCH=4, OUT3_HZ=CLK_HZ -> ce_o[3] constantly 1 from release.
  - resetn asserted mid-RUN clears all outputs asynchronously.
- With CLKCESEQ_RUNTIME_INC_EN:
  - Write ch0 inc=2^22 -> spacing 4 cycles from the next cycle.
  - Write ch3 with NCH=3 -> no effect.
  - Write inc=0 -> ce_o[0] stops.
